// File: rtl/l2tlb_dr_arb.sv
// l2tlb_dr_arb: shares the L2-to-directory request channel and the directory
// snack return channel between the L2 cache controller and the L2TLB.
// Requests are merged round-robin into a 2-entry FIFO, with the nodeid LSB
// stamped by source (0 = L2, 1 = L2TLB). Snacks are steered back by that bit.
// Per-source outstanding counters cap how many requests each side has in flight.
module l2tlb_dr_arb #(
    parameter int REQ_W         = 64,
    parameter int SNACK_W       = 64,
    parameter int REQ_NID_BIT   = 0,
    parameter int SNACK_NID_BIT = 0,
    parameter int MAX_OUT       = 4,
    parameter int CW            = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               l2_req_valid,
    output logic               l2_req_retry,
    input  logic [REQ_W-1:0]   l2_req,

    input  logic               tlb_req_valid,
    output logic               tlb_req_retry,
    input  logic [REQ_W-1:0]   tlb_req,

    output logic               l2todr_req_valid,
    input  logic               l2todr_req_retry,
    output logic [REQ_W-1:0]   l2todr_req,

    input  logic               drtol2_snack_valid,
    output logic               drtol2_snack_retry,
    input  logic [SNACK_W-1:0] drtol2_snack,

    output logic               l2_snack_valid,
    input  logic               l2_snack_retry,
    output logic [SNACK_W-1:0] l2_snack,

    output logic               tlb_snack_valid,
    input  logic               tlb_snack_retry,
    output logic [SNACK_W-1:0] tlb_snack,

    output logic [CW-1:0]      l2_outstanding,
    output logic [CW-1:0]      tlb_outstanding
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    // Request FIFO state: two slots, read/write slot pointers and occupancy.
    logic [REQ_W-1:0] fifo_mem [2];
    logic             fifo_rd;
    logic             fifo_wr;
    logic [1:0]       fifo_cnt;

    // Round-robin pointer: 0 favours L2, 1 favours the L2TLB.
    logic             rr_ptr;

    logic [CW-1:0]    l2_cnt;
    logic [CW-1:0]    tlb_cnt;

    // Single-entry snack holding register.
    logic               sv;
    logic [SNACK_W-1:0] sdata;

    logic             l2_elig;
    logic             tlb_elig;
    logic             grant_l2;
    logic             grant_tlb;
    logic             deq;
    logic             space;
    logic             acc_l2;
    logic             acc_tlb;
    logic             enq;
    logic [REQ_W-1:0] enq_data;

    logic             snack_to_tlb;
    logic             drain;
    logic             snack_acc;
    logic             dec_l2;
    logic             dec_tlb;

    // Arbitration: a source competes only while below its outstanding cap.
    assign l2_elig   = l2_req_valid  && (l2_cnt  < MAX_C);
    assign tlb_elig  = tlb_req_valid && (tlb_cnt < MAX_C);
    assign grant_l2  = l2_elig  && (!tlb_elig || !rr_ptr);
    assign grant_tlb = tlb_elig && (!l2_elig  ||  rr_ptr);

    // A full FIFO still has room when its head leaves in the same cycle.
    assign deq   = (fifo_cnt != 2'd0) && !l2todr_req_retry;
    assign space = (fifo_cnt < 2'd2) || deq;

    assign acc_l2  = grant_l2  && space;
    assign acc_tlb = grant_tlb && space;
    assign enq     = acc_l2 || acc_tlb;

    assign l2_req_retry  = !acc_l2;
    assign tlb_req_retry = !acc_tlb;

    assign l2todr_req_valid = (fifo_cnt != 2'd0);
    assign l2todr_req       = fifo_mem[fifo_rd];

    // Stamp the winning payload with its source parity in the nodeid LSB.
    // NOTE: every signal written in always_comb is given a full default first,
    // so no path leaves it holding its old value and no latch is inferred.
    always_comb begin
        enq_data              = grant_tlb ? tlb_req : l2_req;
        enq_data[REQ_NID_BIT] = grant_tlb;
    end

    // Request FIFO: enqueue at the tail, dequeue from the head, track occupancy.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; the two slots are reset too so the payload
    // output is 0 rather than X straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (enq) begin
                fifo_mem[fifo_wr] <= enq_data;
                fifo_wr           <= ~fifo_wr;
            end
            if (deq) begin
                fifo_rd <= ~fifo_rd;
            end
            unique case ({enq, deq})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Round-robin pointer: after each accepted grant, favour the other source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (acc_l2) begin
            rr_ptr <= 1'b1;
        end else if (acc_tlb) begin
            rr_ptr <= 1'b0;
        end
    end

    // Snack steering: the held snack's nodeid LSB selects its destination.
    assign snack_to_tlb       = sdata[SNACK_NID_BIT];
    assign l2_snack_valid     = sv && !snack_to_tlb;
    assign tlb_snack_valid    = sv &&  snack_to_tlb;
    assign l2_snack           = sdata;
    assign tlb_snack          = sdata;
    assign drain              = sv && (snack_to_tlb ? !tlb_snack_retry : !l2_snack_retry);
    assign drtol2_snack_retry = sv && !drain;
    assign snack_acc          = drtol2_snack_valid && !drtol2_snack_retry;

    // Snack register: refill on accept (also while draining), empty on drain alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sv    <= 1'b0;
            sdata <= '0;
        end else if (snack_acc) begin
            sv    <= 1'b1;
            sdata <= drtol2_snack;
        end else if (drain) begin
            sv    <= 1'b0;
        end
    end

    assign dec_l2  = drain && !snack_to_tlb;
    assign dec_tlb = drain &&  snack_to_tlb;

    // Outstanding counters: +1 on accepted request, -1 (floored at 0) on delivered snack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l2_cnt  <= '0;
            tlb_cnt <= '0;
        end else begin
            unique case ({acc_l2, dec_l2})
                2'b10:   l2_cnt <= l2_cnt + ONE_C;
                2'b01:   l2_cnt <= (l2_cnt != '0) ? l2_cnt - ONE_C : l2_cnt;
                default: l2_cnt <= l2_cnt;
            endcase
            unique case ({acc_tlb, dec_tlb})
                2'b10:   tlb_cnt <= tlb_cnt + ONE_C;
                2'b01:   tlb_cnt <= (tlb_cnt != '0) ? tlb_cnt - ONE_C : tlb_cnt;
                default: tlb_cnt <= tlb_cnt;
            endcase
        end
    end

    assign l2_outstanding  = l2_cnt;
    assign tlb_outstanding = tlb_cnt;

endmodule

// File: tb/tb_l2tlb_dr_arb.sv
// Testbench for l2tlb_dr_arb: directed scenarios per feature, with scoreboard
// queues filled when stimulus is accepted and drained by output monitors.
module tb_l2tlb_dr_arb;

    localparam int REQ_W         = 64;
    localparam int SNACK_W       = 64;
    localparam int REQ_NID_BIT   = 0;
    localparam int SNACK_NID_BIT = 0;
    localparam int MAX_OUT       = 4;
    localparam int CW            = 4;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               l2_req_valid = 1'b0;
    logic               l2_req_retry;
    logic [REQ_W-1:0]   l2_req = '0;
    logic               tlb_req_valid = 1'b0;
    logic               tlb_req_retry;
    logic [REQ_W-1:0]   tlb_req = '0;
    logic               l2todr_req_valid;
    logic               l2todr_req_retry = 1'b0;
    logic [REQ_W-1:0]   l2todr_req;
    logic               drtol2_snack_valid = 1'b0;
    logic               drtol2_snack_retry;
    logic [SNACK_W-1:0] drtol2_snack = '0;
    logic               l2_snack_valid;
    logic               l2_snack_retry = 1'b0;
    logic [SNACK_W-1:0] l2_snack;
    logic               tlb_snack_valid;
    logic               tlb_snack_retry = 1'b0;
    logic [SNACK_W-1:0] tlb_snack;
    logic [CW-1:0]      l2_outstanding;
    logic [CW-1:0]      tlb_outstanding;

    int vectors     = 0;
    int miscompares = 0;

    logic [REQ_W-1:0]   req_q  [$];
    logic [SNACK_W-1:0] l2s_q  [$];
    logic [SNACK_W-1:0] tlbs_q [$];

    logic [REQ_W-1:0]   mon_req_exp;
    logic [SNACK_W-1:0] mon_l2s_exp;
    logic [SNACK_W-1:0] mon_tlbs_exp;

    l2tlb_dr_arb #(
        .REQ_W(REQ_W), .SNACK_W(SNACK_W), .REQ_NID_BIT(REQ_NID_BIT),
        .SNACK_NID_BIT(SNACK_NID_BIT), .MAX_OUT(MAX_OUT), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .l2_req_valid(l2_req_valid), .l2_req_retry(l2_req_retry), .l2_req(l2_req),
        .tlb_req_valid(tlb_req_valid), .tlb_req_retry(tlb_req_retry), .tlb_req(tlb_req),
        .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry),
        .l2todr_req(l2todr_req),
        .drtol2_snack_valid(drtol2_snack_valid), .drtol2_snack_retry(drtol2_snack_retry),
        .drtol2_snack(drtol2_snack),
        .l2_snack_valid(l2_snack_valid), .l2_snack_retry(l2_snack_retry), .l2_snack(l2_snack),
        .tlb_snack_valid(tlb_snack_valid), .tlb_snack_retry(tlb_snack_retry),
        .tlb_snack(tlb_snack),
        .l2_outstanding(l2_outstanding), .tlb_outstanding(tlb_outstanding)
    );

    always #5 clk = ~clk;

    // Expected request as it should leave the block: nodeid LSB set to source parity.
    function automatic logic [REQ_W-1:0] stamp(input logic [REQ_W-1:0] d, input logic from_tlb);
        logic [REQ_W-1:0] r;
        r = d;
        r[REQ_NID_BIT] = from_tlb;
        return r;
    endfunction

    // Output monitors: inputs are stable at the falling edge, so a handshake
    // seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (reset && l2todr_req_valid && !l2todr_req_retry) begin
            vectors++;
            if (req_q.size() == 0) begin
                miscompares++;
                $display("FAIL req_out: got unexpected %h, want no request", l2todr_req);
            end else begin
                mon_req_exp = req_q.pop_front();
                if (l2todr_req !== mon_req_exp) begin
                    miscompares++;
                    $display("FAIL req_out: got %h, want %h", l2todr_req, mon_req_exp);
                end
            end
        end
        if (reset && l2_snack_valid && !l2_snack_retry) begin
            vectors++;
            if (l2s_q.size() == 0) begin
                miscompares++;
                $display("FAIL l2_snack: got unexpected %h, want no snack", l2_snack);
            end else begin
                mon_l2s_exp = l2s_q.pop_front();
                if (l2_snack !== mon_l2s_exp) begin
                    miscompares++;
                    $display("FAIL l2_snack: got %h, want %h", l2_snack, mon_l2s_exp);
                end
            end
        end
        if (reset && tlb_snack_valid && !tlb_snack_retry) begin
            vectors++;
            if (tlbs_q.size() == 0) begin
                miscompares++;
                $display("FAIL tlb_snack: got unexpected %h, want no snack", tlb_snack);
            end else begin
                mon_tlbs_exp = tlbs_q.pop_front();
                if (tlb_snack !== mon_tlbs_exp) begin
                    miscompares++;
                    $display("FAIL tlb_snack: got %h, want %h", tlb_snack, mon_tlbs_exp);
                end
            end
        end
    end

    task automatic idle_inputs();
        l2_req_valid       = 1'b0;
        tlb_req_valid      = 1'b0;
        drtol2_snack_valid = 1'b0;
        l2todr_req_retry   = 1'b0;
        l2_snack_retry     = 1'b0;
        tlb_snack_retry    = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        req_q.delete();
        l2s_q.delete();
        tlbs_q.delete();
        next_cycle();
        reset = 1'b1;
    endtask

    // Let every queued item leave, bounded; then nothing further may be pending.
    task automatic drain_wait(input string name);
        int n;
        n = 0;
        idle_inputs();
        do begin
            next_cycle();
            n++;
        end while ((req_q.size() != 0 || l2s_q.size() != 0 || tlbs_q.size() != 0) && n < 50);
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d items still expected after %0d cycles, want 0",
                     name, req_q.size() + l2s_q.size() + tlbs_q.size(), n);
        end
        vectors++;
        if ({l2todr_req_valid, l2_snack_valid, tlb_snack_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s_idle: got valids %b, want 000", name,
                     {l2todr_req_valid, l2_snack_valid, tlb_snack_valid});
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        vectors++;
        if ({l2todr_req_valid, l2_snack_valid, tlb_snack_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_valids: got %b, want 000",
                     {l2todr_req_valid, l2_snack_valid, tlb_snack_valid});
        end
        vectors++;
        if (l2_outstanding !== 4'd0 || tlb_outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_counts: got %0d/%0d, want 0/0", l2_outstanding, tlb_outstanding);
        end
        vectors++;
        if ({drtol2_snack_retry, l2_req_retry, tlb_req_retry} !== 3'b011) begin
            miscompares++;
            $display("FAIL reset_retries: got %b, want 011",
                     {drtol2_snack_retry, l2_req_retry, tlb_req_retry});
        end
        vectors++;
        if (l2todr_req !== 64'd0 || l2_snack !== 64'd0 || tlb_snack !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_payloads: got %h/%h/%h, want zeros", l2todr_req, l2_snack, tlb_snack);
        end
        l2_req_valid  = 1'b1;
        tlb_req_valid = 1'b1;
        #1;
        vectors++;
        if ({l2_req_retry, tlb_req_retry} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_winner: got retries %b, want 01", {l2_req_retry, tlb_req_retry});
        end
        l2_req_valid  = 1'b0;
        tlb_req_valid = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_alternate();
        int li, ti;
        logic exp_l2;
        apply_reset();
        li = 0;
        ti = 0;
        for (int k = 0; k < 4; k++) begin
            l2_req_valid  = 1'b1;
            tlb_req_valid = 1'b1;
            l2_req  = {32'hA5A5_0000, 32'(li * 3 + 1)};
            tlb_req = {32'h5A5A_0000, 32'(ti * 5 + 2)};
            exp_l2  = (k % 2 == 0);
            @(negedge clk);
            vectors++;
            if ({l2_req_retry, tlb_req_retry} !== {!exp_l2, exp_l2}) begin
                miscompares++;
                $display("FAIL alt_grant%0d: got retries %b, want %b", k,
                         {l2_req_retry, tlb_req_retry}, {!exp_l2, exp_l2});
            end
            vectors++;
            if (l2todr_req_valid !== (k != 0)) begin
                miscompares++;
                $display("FAIL alt_outvalid%0d: got %b, want %b", k, l2todr_req_valid, k != 0);
            end
            if (exp_l2) begin
                req_q.push_back(stamp(l2_req, 1'b0));
                li++;
            end else begin
                req_q.push_back(stamp(tlb_req, 1'b1));
                ti++;
            end
            next_cycle();
        end
        l2_req_valid  = 1'b0;
        tlb_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (l2todr_req_valid !== 1'b1 || l2_outstanding !== 4'd2 || tlb_outstanding !== 4'd2) begin
            miscompares++;
            $display("FAIL alt_tail: got valid %b counts %0d/%0d, want 1 2/2",
                     l2todr_req_valid, l2_outstanding, tlb_outstanding);
        end
        next_cycle();
        drain_wait("alt");
    endtask

    task automatic test_stamp();
        apply_reset();
        tlb_req_valid = 1'b1;
        tlb_req       = 64'h0;
        @(negedge clk);
        vectors++;
        if (tlb_req_retry !== 1'b0) begin
            miscompares++;
            $display("FAIL stamp_tlb_acc: got retry %b, want 0", tlb_req_retry);
        end
        req_q.push_back(64'h0000_0000_0000_0001);
        next_cycle();
        tlb_req_valid = 1'b0;
        l2_req_valid  = 1'b1;
        l2_req        = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        vectors++;
        if (l2_req_retry !== 1'b0) begin
            miscompares++;
            $display("FAIL stamp_l2_acc: got retry %b, want 0", l2_req_retry);
        end
        req_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        next_cycle();
        drain_wait("stamp");
    endtask

    task automatic test_backpressure();
        logic [REQ_W-1:0] la, lb, ta, tb;
        logic [1:0] exp_r [6];
        la = 64'h1111_0000_0000_0001;
        lb = 64'h2222_0000_0000_0003;
        ta = 64'h3333_0000_0000_0004;
        tb = 64'h4444_0000_0000_0006;
        exp_r = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            l2todr_req_retry = (c != 4);
            l2_req_valid     = (c < 5);
            tlb_req_valid    = 1'b1;
            l2_req           = (c == 0) ? la : lb;
            tlb_req          = (c < 2) ? ta : tb;
            @(negedge clk);
            vectors++;
            if ({l2_req_retry, tlb_req_retry} !== exp_r[c]) begin
                miscompares++;
                $display("FAIL bp_retry%0d: got %b, want %b", c,
                         {l2_req_retry, tlb_req_retry}, exp_r[c]);
            end
            if (c == 2) begin
                vectors++;
                if (l2todr_req_valid !== 1'b1 || l2todr_req !== stamp(la, 1'b0)) begin
                    miscompares++;
                    $display("FAIL bp_head: got %b %h, want 1 %h", l2todr_req_valid,
                             l2todr_req, stamp(la, 1'b0));
                end
            end
            if (c == 0) req_q.push_back(stamp(la, 1'b0));
            if (c == 1) req_q.push_back(stamp(ta, 1'b1));
            if (c == 4) req_q.push_back(stamp(lb, 1'b0));
            next_cycle();
        end
        vectors++;
        if (l2_outstanding !== 4'd2 || tlb_outstanding !== 4'd1) begin
            miscompares++;
            $display("FAIL bp_counts: got %0d/%0d, want 2/1", l2_outstanding, tlb_outstanding);
        end
        drain_wait("bp");
    endtask

    task automatic test_outstanding();
        logic [SNACK_W-1:0] s;
        apply_reset();
        s = 64'h5555_0000_0000_0002;
        for (int k = 0; k < 4; k++) begin
            l2_req_valid = 1'b1;
            l2_req       = {32'hC0DE_0000, 32'(k * 7 + 1)};
            @(negedge clk);
            vectors++;
            if (l2_req_retry !== 1'b0) begin
                miscompares++;
                $display("FAIL out_acc%0d: got retry %b, want 0", k, l2_req_retry);
            end
            req_q.push_back(stamp(l2_req, 1'b0));
            next_cycle();
        end
        l2_req        = 64'hC0DE_0000_0000_0099;
        tlb_req_valid = 1'b1;
        tlb_req       = 64'h7777_0000_0000_0000;
        @(negedge clk);
        vectors++;
        if ({l2_req_retry, tlb_req_retry} !== 2'b10 || l2_outstanding !== 4'd4) begin
            miscompares++;
            $display("FAIL out_cap: got retries %b count %0d, want 10 4",
                     {l2_req_retry, tlb_req_retry}, l2_outstanding);
        end
        req_q.push_back(stamp(tlb_req, 1'b1));
        next_cycle();
        tlb_req_valid      = 1'b0;
        drtol2_snack_valid = 1'b1;
        drtol2_snack       = s;
        @(negedge clk);
        vectors++;
        if ({drtol2_snack_retry, l2_req_retry} !== 2'b01 || l2_outstanding !== 4'd4) begin
            miscompares++;
            $display("FAIL out_snack_in: got snack_retry/l2_retry %b count %0d, want 01 4",
                     {drtol2_snack_retry, l2_req_retry}, l2_outstanding);
        end
        l2s_q.push_back(s);
        next_cycle();
        drtol2_snack_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({l2_snack_valid, l2_req_retry} !== 2'b11 || l2_outstanding !== 4'd4) begin
            miscompares++;
            $display("FAIL out_snack_out: got snack_valid/l2_retry %b count %0d, want 11 4",
                     {l2_snack_valid, l2_req_retry}, l2_outstanding);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (l2_req_retry !== 1'b0 || l2_outstanding !== 4'd3) begin
            miscompares++;
            $display("FAIL out_reopen: got retry %b count %0d, want 0 3", l2_req_retry, l2_outstanding);
        end
        req_q.push_back(stamp(l2_req, 1'b0));
        next_cycle();
        l2_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (l2_outstanding !== 4'd4 || tlb_outstanding !== 4'd1) begin
            miscompares++;
            $display("FAIL out_final: got %0d/%0d, want 4/1", l2_outstanding, tlb_outstanding);
        end
        next_cycle();
        drain_wait("out");
    endtask

    task automatic test_snack_order();
        logic [SNACK_W-1:0] sa, sb, sc;
        sa = 64'hAAAA_0000_0000_0010;
        sb = 64'hBBBB_0000_0000_0021;
        sc = 64'hCCCC_0000_0000_0030;
        apply_reset();
        drtol2_snack_valid = 1'b1;
        drtol2_snack       = sa;
        @(negedge clk);
        vectors++;
        if (drtol2_snack_retry !== 1'b0) begin
            miscompares++;
            $display("FAIL snk_a_in: got retry %b, want 0", drtol2_snack_retry);
        end
        l2s_q.push_back(sa);
        next_cycle();
        drtol2_snack    = sb;
        tlb_snack_retry = 1'b1;
        @(negedge clk);
        vectors++;
        if ({drtol2_snack_retry, l2_snack_valid, tlb_snack_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL snk_a_out: got retry/l2v/tlbv %b, want 010",
                     {drtol2_snack_retry, l2_snack_valid, tlb_snack_valid});
        end
        tlbs_q.push_back(sb);
        next_cycle();
        drtol2_snack = sc;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({drtol2_snack_retry, l2_snack_valid, tlb_snack_valid} !== 3'b101 ||
                tlb_snack !== sb) begin
                miscompares++;
                $display("FAIL snk_stall%0d: got retry/l2v/tlbv %b data %h, want 101 %h", c,
                         {drtol2_snack_retry, l2_snack_valid, tlb_snack_valid}, tlb_snack, sb);
            end
            next_cycle();
        end
        tlb_snack_retry = 1'b0;
        @(negedge clk);
        vectors++;
        if ({drtol2_snack_retry, tlb_snack_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL snk_release: got retry/tlbv %b, want 01",
                     {drtol2_snack_retry, tlb_snack_valid});
        end
        l2s_q.push_back(sc);
        next_cycle();
        drtol2_snack_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({l2_snack_valid, tlb_snack_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL snk_c_out: got l2v/tlbv %b, want 10", {l2_snack_valid, tlb_snack_valid});
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (l2_outstanding !== 4'd0 || tlb_outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL snk_floor: got %0d/%0d, want 0/0", l2_outstanding, tlb_outstanding);
        end
        next_cycle();
        drain_wait("snk");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        l2todr_req_retry   = 1'b1;
        l2_snack_retry     = 1'b1;
        l2_req_valid       = 1'b1;
        tlb_req_valid      = 1'b1;
        l2_req             = 64'h9999_0000_0000_0001;
        tlb_req            = 64'h8888_0000_0000_0000;
        drtol2_snack_valid = 1'b1;
        drtol2_snack       = 64'h6666_0000_0000_0000;
        next_cycle();
        drtol2_snack_valid = 1'b0;
        l2_req             = 64'h9999_0000_0000_0003;
        next_cycle();
        l2_req_valid  = 1'b0;
        tlb_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({l2todr_req_valid, l2_snack_valid} !== 2'b11 ||
            l2_outstanding !== 4'd1 || tlb_outstanding !== 4'd1) begin
            miscompares++;
            $display("FAIL rm_pre: got valids %b counts %0d/%0d, want 11 1/1",
                     {l2todr_req_valid, l2_snack_valid}, l2_outstanding, tlb_outstanding);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({l2todr_req_valid, l2_snack_valid, tlb_snack_valid} !== 3'b000 ||
            l2_outstanding !== 4'd0 || tlb_outstanding !== 4'd0) begin
            miscompares++;
            $display("FAIL rm_async: got valids %b counts %0d/%0d, want 000 0/0",
                     {l2todr_req_valid, l2_snack_valid, tlb_snack_valid},
                     l2_outstanding, tlb_outstanding);
        end
        req_q.delete();
        l2s_q.delete();
        tlbs_q.delete();
        idle_inputs();
        next_cycle();
        reset = 1'b1;
        l2_req_valid  = 1'b1;
        tlb_req_valid = 1'b1;
        l2_req        = 64'h1234_0000_0000_0005;
        tlb_req       = 64'h4321_0000_0000_0002;
        @(negedge clk);
        vectors++;
        if ({l2_req_retry, tlb_req_retry} !== 2'b01) begin
            miscompares++;
            $display("FAIL rm_first_grant: got retries %b, want 01", {l2_req_retry, tlb_req_retry});
        end
        req_q.push_back(stamp(l2_req, 1'b0));
        next_cycle();
        drain_wait("rm");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alternate();
        test_stamp();
        test_backpressure();
        test_outstanding();
        test_snack_order();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2tlb_dr_arb.md
# l2tlb_dr_arb

Arbiter and router that shares the single L2-to-directory request channel and the directory snack return channel between the L2 cache controller and the L2TLB. Requests from both sources are merged round-robin into a 2-entry output FIFO. Each request's nodeid LSB is stamped with the source's parity: even for L2, odd for L2TLB. Snacks are steered back by that same bit. Per-source outstanding counters cap how many requests each side may have in flight. The block is instantiated inside the l2cache, between its internal request/response logic and the directory ports.

## Interface
- REQ_W, 64, request payload width
- SNACK_W, 64, snack payload width
- REQ_NID_BIT, 0, bit index of the nodeid LSB in the request payload
- SNACK_NID_BIT, 0, bit index of the nodeid LSB in the snack payload
- MAX_OUT, 4, maximum outstanding requests per source (1..15)
- CW, 4, outstanding-counter width; must be at least clog2(MAX_OUT+1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- l2_req_valid / l2_req_retry / l2_req  in/out/in  1/1/REQ_W  L2 request source
- tlb_req_valid / tlb_req_retry / tlb_req  in/out/in  1/1/REQ_W  L2TLB request source
- l2todr_req_valid / l2todr_req_retry / l2todr_req  out/in/out  1/1/REQ_W  merged request to directory
- drtol2_snack_valid / drtol2_snack_retry / drtol2_snack  in/out/in  1/1/SNACK_W  snack from directory
- l2_snack_valid / l2_snack_retry / l2_snack  out/in/out  1/1/SNACK_W  snack to L2
- tlb_snack_valid / tlb_snack_retry / tlb_snack  out/in/out  1/1/SNACK_W  snack to L2TLB
- l2_outstanding, tlb_outstanding  out  CW  current outstanding counts

## Operation
**Handshake**
- A transfer happens in a cycle where `valid=1` and `retry=0`.
- The sender holds payload stable while `valid=1`.

**Eligibility and FIFO space**
- A source is eligible when `x_valid` is high and `x_outstanding < MAX_OUT`.
- Space exists when the FIFO count is below 2, or when the count is 2 and the head dequeues this cycle (`l2todr_req_valid & !l2todr_req_retry`).

**Request arbitration**
- With one eligible source, that source is granted.
- With both eligible, the round-robin pointer picks the winner.
- After every grant, the pointer points to the other source.
- `x_retry = !(grant_x & space)`. It is combinational from registered state, `x_valid`, the other source's valid, and `l2todr_req_retry`.

**Enqueue**
- The granted payload is written into the FIFO tail.
- Bit REQ_NID_BIT is forced to 0 for L2 and to 1 for TLB; all other bits pass unchanged.
- The FIFO head drives `l2todr_req`. `l2todr_req_valid` is high whenever the FIFO is non-empty.

**Snack path**
- The snack path has a 1-entry register (`sv`, `sdata`). `drtol2_snack_retry = sv & !drain`.
- `drain` means the selected output transfers this cycle, which allows back-to-back fill on drain.
- If `sdata[SNACK_NID_BIT]=0`, `sv` drives `l2_snack_valid`; otherwise it drives `tlb_snack_valid`. The other output stays 0.
- Both payload outputs carry `sdata`. Snack order is preserved.

**Outstanding counters**
- A counter increments when its source's request is accepted.
- It decrements when a snack transfers to that source.
- Increment and decrement in the same cycle leave the counter unchanged.
- The decrement saturates at 0; the snack is still delivered.

**Reset (reset=0, asynchronous)**
- FIFO is emptied and `sv` is cleared.
- Counters go to 0 and the pointer is set to favour L2.
- All `*_valid` outputs are 0.
- Retry outputs follow their combinational equations: `drtol2_snack_retry`=0; each `x_req_retry`=1 unless that source would win with space available.
- Payload outputs are don't-care but must not be X-propagating; drive 0 on reset.
- Reset asserted mid-transfer discards all buffered requests and snacks.

## Timing
- Request accepted at cycle N appears on `l2todr_req` at N+1 at the earliest.
- Throughput is one request per cycle with sustained `l2todr_req_retry=0`.
- Snack accepted at cycle N is presented at N+1.
- Sustained throughput is one snack per cycle when the destination never retries.
- Counter updates are visible on the `*_outstanding` outputs the cycle after the event.
- When the FIFO is full and `l2todr_req_retry=1`, both sources see `retry=1`.
- When the FIFO is full and dequeuing, one source may enqueue in the same cycle.

## Test plan
- Both sources valid every cycle, directory never retries → grants alternate L2, TLB, L2, TLB…; 4 requests emerge at cycles 1–4; nodeid bit alternates 0,1,0,1.
- TLB sends payload 0x0 and L2 sends 0xFF..FF (REQ_NID_BIT=0) → TLB output is 0x1 and L2 output is 0xFF..FE.
- `l2todr_req_retry` held at 1 → exactly 2 requests are accepted, then both retries stay 1. Release retry for one cycle → one dequeue and one enqueue in that same cycle.
- L2 issues MAX_OUT=4 requests with no snacks → 5th is retried and `l2_outstanding`=4. TLB is still accepted. One snack with bit=0 delivered to L2 → counter drops to 3 next cycle and L2 is accepted again.
- Snacks with nid bits 0,1,0 back-to-back, `tlb_snack_retry`=1 for 3 cycles → first goes to L2 at cycle 1; second stalls on TLB and `drtol2_snack_retry`=1 for 3 cycles; order is preserved.
- Assert reset with FIFO=2 and `sv=1` → all valids are 0 immediately, counters are 0, and the first grant after release goes to L2.
